// File: rtl/mux2x1_hot_encoded_merge.sv
// Round-robin 2:1 stream merge with atomic bursts and a 2-entry tagged output FIFO.
// Each output beat carries a one-hot source ID and a last-of-burst flag for response routing.
module mux2x1_hot_encoded_merge #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in0_valid,
  input  logic [DATA_WIDTH-1:0] in0_data,
  output logic                  in0_ready,
  input  logic                  in1_valid,
  input  logic [DATA_WIDTH-1:0] in1_data,
  output logic                  in1_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_src,
  output logic                  out_last,
  output logic [1:0]            grant
);

  // The state encoding is the one-hot grant itself, so grant comes straight off the register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            src;
    logic                  last;
  } beat_t;

  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_beat_cnt;
  logic       r_last_served;
  beat_t      r_fifo [2];
  logic [1:0] r_count;

  logic  w_room;
  logic  w_acc0;
  logic  w_acc1;
  logic  w_push;
  logic  w_pop;
  logic  w_is_last;
  beat_t w_beat;

  assign w_room    = (r_count != 2'd2);
  assign in0_ready = (r_state == ST_G0) && w_room;
  assign in1_ready = (r_state == ST_G1) && w_room;
  assign w_acc0    = in0_valid && in0_ready;
  assign w_acc1    = in1_valid && in1_ready;
  assign w_push    = w_acc0 || w_acc1;
  assign w_pop     = out_valid && out_ready;
  assign w_is_last = (r_beat_cnt == LAST_IDX);

  assign w_beat.data = w_acc1 ? in1_data : in0_data;
  assign w_beat.src  = w_acc1 ? 2'b10 : 2'b01;
  assign w_beat.last = w_is_last;

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_fifo[0].data;
  assign out_src   = r_fifo[0].src;
  assign out_last  = r_fifo[0].last;
  assign grant     = r_state;

  // NOTE: next-state is assigned a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (in0_valid && in1_valid) w_state_nxt = r_last_served ? ST_G0 : ST_G1;
        else if (in0_valid)         w_state_nxt = ST_G0;
        else if (in1_valid)         w_state_nxt = ST_G1;
      end
      // The finishing source's valid is consumed by its last beat, so only the
      // other source can take the next grant without a pass through IDLE.
      ST_G0: if (w_acc0 && w_is_last) w_state_nxt = in1_valid ? ST_G1 : ST_IDLE;
      ST_G1: if (w_acc1 && w_is_last) w_state_nxt = in0_valid ? ST_G0 : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_beat_cnt    <= 8'd0;
      r_last_served <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_beat_cnt <= w_is_last ? 8'd0 : r_beat_cnt + 8'd1;
        if (w_is_last) r_last_served <= w_acc1;
      end
    end
  end

  // NOTE: the FIFO entries are reset because the head entry drives out_* directly and must read zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_count   <= 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_fifo[0] <= w_beat;
          else                 r_fifo[1] <= w_beat;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          // With one entry left the head simply holds its stale value.
          if (r_count == 2'd2) r_fifo[0] <= r_fifo[1];
          r_count <= r_count - 2'd1;
        end
        2'b11: r_fifo[0] <= w_beat;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux2x1_hot_encoded_merge.sv
// Bench for mux2x1_hot_encoded_merge: a BURST_LEN=4 and a BURST_LEN=1 instance checked
// every cycle against a queue-based transaction model, plus directed vectors and sequences.
module tb_mux2x1_hot_encoded_merge;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   src;
    logic         last;
  } beat_t;

  typedef struct {
    logic         rst_n;
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    logic         ordy;
    logic [1:0]   g;
    logic         r0;
    logic         r1;
    logic         ov;
    logic [W-1:0] od;
    logic [1:0]   os;
    logic         ol;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         v0 [2];
  logic         v1 [2];
  logic         ordy [2];
  logic [W-1:0] d0 [2];
  logic [W-1:0] d1 [2];
  logic         r0 [2];
  logic         r1 [2];
  logic         ov [2];
  logic         ol [2];
  logic [W-1:0] od [2];
  logic [1:0]   os [2];
  logic [1:0]   gr [2];

  int    bl [2] = '{4, 1};
  int    m_owner [2];
  int    m_cnt [2];
  int    m_ls [2];
  beat_t m_q [2][$];
  logic  m_acc0 [2];
  logic  m_acc1 [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux2x1_hot_encoded_merge #(.DATA_WIDTH(W), .BURST_LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(v0[0]), .in0_data(d0[0]), .in0_ready(r0[0]),
    .in1_valid(v1[0]), .in1_data(d1[0]), .in1_ready(r1[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .out_src(os[0]), .out_last(ol[0]), .grant(gr[0])
  );

  mux2x1_hot_encoded_merge #(.DATA_WIDTH(W), .BURST_LEN(1)) u_dut_b1 (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(v0[1]), .in0_data(d0[1]), .in0_ready(r0[1]),
    .in1_valid(v1[1]), .in1_data(d1[1]), .in1_ready(r1[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .out_src(os[1]), .out_last(ol[1]), .grant(gr[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int s);
    if (s == 0) return 2'b01;
    if (s == 1) return 2'b10;
    return 2'b00;
  endfunction

  // Round-robin choice among requesters: on a tie the one not served last wins.
  function automatic int pick(input logic a, input logic b, input int ls);
    if (a && b) return (ls == 1) ? 0 : 1;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic step();
    logic  rd0, rd1, pop;
    beat_t b;
    int    src;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_owner[k] = -1;
        m_cnt[k]   = 0;
        m_ls[k]    = 1;
        m_q[k].delete();
        m_acc0[k]  = 1'b0;
        m_acc1[k]  = 1'b0;
      end else begin
        rd0 = (m_owner[k] == 0) && (m_q[k].size() < 2);
        rd1 = (m_owner[k] == 1) && (m_q[k].size() < 2);
        m_acc0[k] = v0[k] && rd0;
        m_acc1[k] = v1[k] && rd1;
        pop = (m_q[k].size() > 0) && ordy[k];
        if (pop) void'(m_q[k].pop_front());
        if (m_acc0[k] || m_acc1[k]) begin
          src    = m_acc1[k] ? 1 : 0;
          b.data = (src == 1) ? d1[k] : d0[k];
          b.src  = onehot(src);
          b.last = (m_cnt[k] == bl[k] - 1);
          m_q[k].push_back(b);
          if (b.last) begin
            m_cnt[k]   = 0;
            m_ls[k]    = src;
            m_owner[k] = ((src == 0) ? v1[k] : v0[k]) ? 1 - src : -1;
          end else begin
            m_cnt[k]++;
          end
        end else if (m_owner[k] < 0) begin
          m_owner[k] = pick(v0[k], v1[k], m_ls[k]);
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("k%0d_grant", k), gr[k], onehot(m_owner[k]));
      check($sformatf("k%0d_in0_ready", k), r0[k], (m_owner[k] == 0) && (m_q[k].size() < 2));
      check($sformatf("k%0d_in1_ready", k), r1[k], (m_owner[k] == 1) && (m_q[k].size() < 2));
      check($sformatf("k%0d_out_valid", k), ov[k], m_q[k].size() > 0);
      if (m_q[k].size() > 0) begin
        check($sformatf("k%0d_out_data", k), od[k], m_q[k][0].data);
        check($sformatf("k%0d_out_src", k), os[k], m_q[k][0].src);
        check($sformatf("k%0d_out_last", k), ol[k], m_q[k][0].last);
      end
    end
  endtask

  // One clock: model advances on the edge, DUT compared on the falling edge,
  // then each source moves to its next word once its beat was taken.
  task automatic tick();
    @(posedge clk);
    step();
    @(negedge clk);
    compare_all();
    for (int k = 0; k < 2; k++) begin
      if (m_acc0[k]) d0[k] = d0[k] + 16'd1;
      if (m_acc1[k]) d1[k] = d1[k] + 16'd1;
    end
  endtask

  task automatic quiet(input int k);
    v0[k] = 1'b0; v1[k] = 1'b0; d0[k] = '0; d1[k] = '0; ordy[k] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl [7];
    int   n;

    //            rst v0 d0      v1 d1     ordy g      r0 r1 ov od      os     ol
    tbl[0] = '{1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 16'h1, 1'b0, 16'h0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 16'h1, 1'b0, 16'h0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 16'h1, 2'b01, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 16'h2, 1'b0, 16'h0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 16'h2, 2'b01, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 16'h3, 1'b0, 16'h0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 16'h3, 2'b01, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'h4, 1'b0, 16'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 16'h4, 2'b01, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 1'b0};

    rst_n = 1'b0;
    quiet(0);
    quiet(1);

    // Reset, then a single 4-beat burst from in0.
    for (int i = 0; i < 7; i++) begin
      rst_n = tbl[i].rst_n;
      v0[0] = tbl[i].v0; d0[0] = tbl[i].d0;
      v1[0] = tbl[i].v1; d1[0] = tbl[i].d1;
      ordy[0] = tbl[i].ordy;
      tick();
      check($sformatf("vec%0d_grant", i), gr[0], tbl[i].g);
      check($sformatf("vec%0d_in0_ready", i), r0[0], tbl[i].r0);
      check($sformatf("vec%0d_in1_ready", i), r1[0], tbl[i].r1);
      check($sformatf("vec%0d_out_valid", i), ov[0], tbl[i].ov);
      if (tbl[i].ov || !tbl[i].rst_n) begin
        check($sformatf("vec%0d_out_data", i), od[0], tbl[i].od);
        check($sformatf("vec%0d_out_src", i), os[0], tbl[i].os);
        check($sformatf("vec%0d_out_last", i), ol[0], tbl[i].ol);
      end
    end

    // Both sources always valid: alternating 4-beat bursts at one beat per cycle.
    quiet(0);
    do_reset();
    v0[0] = 1'b1; v1[0] = 1'b1; d0[0] = 16'h1000; d1[0] = 16'h2000;
    tick();
    check("t2_first_grant", gr[0], 2'b01);
    for (int i = 0; i < 24; i++) begin
      tick();
      check($sformatf("t2_busy%0d", i), gr[0] != 2'b00, 1'b1);
      check($sformatf("t2_valid%0d", i), ov[0], 1'b1);
      check($sformatf("t2_src%0d", i), os[0], ((i / 4) % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("t2_last%0d", i), ol[0], (i % 4) == 3);
    end

    // Granted source pauses mid-burst while the other one waits.
    quiet(0);
    do_reset();
    v0[0] = 1'b1; v1[0] = 1'b1; d0[0] = 16'h0100; d1[0] = 16'h0200;
    tick();
    tick();
    tick();
    v0[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_hold_grant%0d", i), gr[0], 2'b01);
      check($sformatf("t3_hold_in1_ready%0d", i), r1[0], 1'b0);
    end
    v0[0] = 1'b1;
    tick();
    tick();
    check("t3_regrant", gr[0], 2'b10);
    check("t3_tail_data", od[0], 16'h0103);
    check("t3_tail_last", ol[0], 1'b1);

    // Downstream stall: two beats fill the FIFO, head holds, then drain in order.
    quiet(0);
    do_reset();
    ordy[0] = 1'b0; v0[0] = 1'b1; d0[0] = 16'h0300;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t4_stall_in0_ready%0d", i), r0[0], i < 1);
      check($sformatf("t4_stall_valid%0d", i), ov[0], 1'b1);
      check($sformatf("t4_stall_head%0d", i), od[0], 16'h0300);
    end
    ordy[0] = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (ov[0]) begin
        check($sformatf("t4_drain%0d", n), od[0], 16'h0300 + 16'(n));
        n++;
      end
      tick();
    end
    check("t4_drained_count", n, 4);

    // Reset in the middle of a burst with the FIFO full.
    quiet(0);
    do_reset();
    ordy[0] = 1'b0; v0[0] = 1'b1; d0[0] = 16'h0400;
    tick();
    tick();
    tick();
    check("t5_full_before_reset", r0[0], 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_out_valid", ov[0], 1'b0);
    check("t5_grant", gr[0], 2'b00);
    check("t5_in0_ready", r0[0], 1'b0);
    check("t5_in1_ready", r1[0], 1'b0);
    check("t5_out_data", od[0], 16'h0000);
    ordy[0] = 1'b1; v0[0] = 1'b1; v1[0] = 1'b1;
    tick();
    check("t5_tie_to_in0", gr[0], 2'b01);

    // Single-beat bursts: sources alternate and every beat is last.
    quiet(0);
    do_reset();
    v0[1] = 1'b1; v1[1] = 1'b1; d0[1] = 16'h0500; d1[1] = 16'h0600;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t6_src%0d", i), os[1], (i % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("t6_last%0d", i), ol[1], 1'b1);
    end

    // Random traffic on both instances, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 2; k++) begin
        v0[k]   = ($urandom_range(0, 3) != 0);
        v1[k]   = ($urandom_range(0, 3) != 0);
        d0[k]   = 16'($urandom);
        d1[k]   = 16'($urandom);
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
